ysyx_25020037_ifu_pf: RTL
=========================

YSYX_25020037_IFU_PF -- requirements
Module: ysyx_25020037_ifu_pf

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 16: refill block in bytes, legal 4/8/16; BEATS = BLOCK_SIZE/4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: fetch-queue entries, power of two, at least BEATS.
REQ-003 SHALL have parameter RESET_PC, default 32'h30000000: first fetch address.
REQ-004 SHALL have parameters BURST_BASE, default 32'hA0000000, and BURST_END, default 32'hBFFFFFFF: inclusive range that takes INCR bursts.
REQ-005 SHALL have ports, one per line:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
redirect_valid  in  1  redirect request, one cycle
redirect_pc  in  32  target PC
out_valid  out  1  queue head valid to IDU
out_ready  in  1  IDU accepts head
out_pc  out  32  head PC
out_inst  out  32  head instruction
out_fault  out  1  head carries access fault
arvalid/arready  out/in  1/1  AXI AR handshake
araddr  out  32  read address
arid  out  4  fixed 0
arlen  out  8  burst length-1
arsize  out  3  fixed 3'h2
arburst  out  2  INCR (1) or FIXED (0)
rvalid/rready  in/out  1/1  AXI R handshake
rdata  in  32  read data
rresp  in  2  response, nonzero = fault
rlast  in  1  last beat

Function
REQ-006 SHALL run FSM IDLE, AR, R, DRAIN, HALT; reset state IDLE.
REQ-007 IDLE -> AR only when free slots (FIFO_DEPTH - count - reserved) >= BEATS; reserves BEATS slots; araddr = fetch_pc with low log2(BLOCK_SIZE) bits cleared.
REQ-008 In the burst range, SHALL issue one AR with arlen=BEATS-1, arburst=1; otherwise BEATS single-beat ARs (arlen=0, arburst=0), addresses base+4*i, each issued only after the prior R beat.
REQ-009 arvalid/araddr/arlen SHALL stay stable from assertion until the cycle arready=1; AR -> R on that cycle.
REQ-010 In R, rready=1; beat i SHALL be enqueued as {base+4*i, rdata, 0} only if base+4*i >= fetch_pc, else discarded; its reservation is released either way.
REQ-011 After the final beat (rlast in burst mode, beat BEATS-1 otherwise), fetch_pc SHALL become base+BLOCK_SIZE and the FSM SHALL return to IDLE.
REQ-012 A beat with rresp!=0 SHALL enqueue {addr, 32'h0, 1}; remaining beats of that block are drained, then HALT; HALT is left only by redirect.
REQ-013 Queue: out_* SHALL show the head combinationally; pop on out_valid&&out_ready; enqueue and pop in one cycle SHALL both take effect; with no reservation outstanding, count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-014 Redirect SHALL flush queue and reservations at the clock edge where it is sampled (out_valid=0 next cycle); fetch_pc<=redirect_pc; a pop in the same cycle counts as delivered.
REQ-015 Redirect in IDLE/HALT SHALL go to IDLE; in AR with arvalid held, the AR SHALL complete, then DRAIN; in R, go to DRAIN.
REQ-016 DRAIN SHALL hold rready=1, discard all beats of the outstanding request (rlast or BEATS single beats), then IDLE; a redirect during DRAIN only updates fetch_pc.
REQ-017 Redirect with redirect_pc[1:0]!=0 SHALL enqueue one {redirect_pc, 0, 1} entry after flush, then HALT, no AR.
REQ-018 Minimum latency: IDLE decision to arvalid=1 is 1 cycle; beat accepted to out_valid=1 is 1 cycle.

Reset
REQ-019 On rst=0 at a clk edge: state IDLE, fetch_pc=RESET_PC, queue empty, reservations 0, out_valid=0, arvalid=0, rready=0, araddr=0, arlen=0, arburst=0, arid=0, arsize=3'h2.
REQ-020 Reset mid-transaction SHALL abandon the transaction immediately; the AXI slave is reset alongside.

Verification
REQ-021 Reset, RESET_PC=0x30000000, BLOCK_SIZE=16, out_ready=1 -> four single ARs 0x30000000/04/08/0C, outputs PCs in order, then AR 0x30000010.
REQ-022 Redirect to 0xA0000008 -> arlen=3, arburst=1, araddr=0xA0000000; beats 0/1 discarded, PCs 0xA0000008, 0xA000000C enqueued.
REQ-023 out_ready=0, FIFO_DEPTH=4 -> exactly one block fetched, no further AR until a pop frees 4 slots.
REQ-024 Redirect during beat 2 of a burst -> remaining beats drained with rready=1, none enqueued; next AR uses the new PC block base.
REQ-025 rresp=2'b10 on beat 1 -> entry with out_fault=1 at that PC, FSM in HALT, no AR until redirect.
REQ-026 redirect_pc=0x30000002 -> single fault entry, no AR issued.

Source files
------------

// File: rtl/ysyx_25020037_ifu_pf.sv
// ysyx_25020037_ifu_pf -- instruction prefetch unit.
//
// Fetches aligned blocks of BLOCK_SIZE bytes over an AXI read channel and
// pushes {pc, inst, fault} entries into a small fetch queue. The IDU pops the
// queue through a valid/ready pair.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   redirect_valid/_pc  one-cycle PC redirect; flushes the queue
//   out_valid/_ready    queue head handshake to IDU
//   out_pc/_inst/_fault queue head contents (combinational from head slot)
//   ar*                 AXI read address channel (arid=0, arsize=4 bytes)
//   r*                  AXI read data channel; rresp != 0 marks an access fault
//
// Addresses in [BURST_BASE, BURST_END] are fetched with one INCR burst.
// Everything else is fetched as BEATS single-beat FIXED reads, one at a time.
// Queue slots are reserved before an AR is issued so every returning beat
// always has room, whatever the IDU does.
module ysyx_25020037_ifu_pf #(
    parameter int          BLOCK_SIZE = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h3000_0000,
    parameter logic [31:0] BURST_BASE = 32'hA000_0000,
    parameter logic [31:0] BURST_END  = 32'hBFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);
    localparam int BEATS = BLOCK_SIZE / 4;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DRAIN, S_HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     base_q, base_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            burst_q, burst_d;
    logic            arvalid_q, arvalid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [7:0]      arlen_q, arlen_d;
    logic [1:0]      arburst_q, arburst_d;
    logic            redir_pend_q, redir_pend_d;  // redirect seen while AR held
    logic            halt_after_q, halt_after_d;  // go to HALT once drain ends
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d, resv_q, resv_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];

    logic [31:0]     blk_base, beat_addr;
    logic            in_range, slots_ok, last_beat, req_done, misalign, pop;
    logic            keep, enq;
    entry_t          enq_entry;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign blk_base  = fetch_pc_q & ~(32'(BLOCK_SIZE) - 32'd1);
    assign in_range  = (blk_base >= BURST_BASE) && (blk_base <= BURST_END);
    assign slots_ok  = (32'(count_q) + 32'(resv_q) + 32'(BEATS)) <= 32'(FIFO_DEPTH);
    assign beat_addr = base_q + (32'(beat_q) << 2);
    assign last_beat = burst_q ? rlast : (beat_q == BW'(BEATS - 1));
    // In single-beat mode only one beat is ever outstanding.
    assign req_done  = rvalid && (burst_q ? rlast : 1'b1);
    assign misalign  = redirect_pc[1:0] != 2'b00;
    assign pop       = out_valid && out_ready;

    assign out_valid = count_q != '0;
    assign out_pc    = mem_q[head_q].pc;
    assign out_inst  = mem_q[head_q].inst;
    assign out_fault = mem_q[head_q].fault;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arburst   = arburst_q;
    assign arid      = 4'h0;
    assign arsize    = 3'h2;
    assign rready    = (state_q == S_R) || (state_q == S_DRAIN);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        base_d       = base_q;
        beat_d       = beat_q;
        burst_d      = burst_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arburst_d    = arburst_q;
        redir_pend_d = redir_pend_q;
        halt_after_d = halt_after_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        resv_d       = resv_q;
        mem_d        = mem_q;
        keep         = 1'b0;
        enq          = 1'b0;
        enq_entry    = '0;

        if (redirect_valid) fetch_pc_d = redirect_pc;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    if (misalign) state_d = S_HALT;
                end else if (slots_ok) begin
                    base_d    = blk_base;
                    beat_d    = '0;
                    burst_d   = in_range;
                    arvalid_d = 1'b1;
                    araddr_d  = blk_base;
                    arlen_d   = in_range ? 8'(BEATS - 1) : 8'h0;
                    arburst_d = in_range ? 2'b01 : 2'b00;
                    resv_d    = resv_q + CW'(BEATS);
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                // The address phase is never withdrawn; a redirect only marks
                // the data that will come back as stale.
                if (redirect_valid) begin
                    redir_pend_d = 1'b1;
                    halt_after_d = misalign;
                end
                if (arready) begin
                    arvalid_d    = 1'b0;
                    redir_pend_d = 1'b0;
                    state_d      = (redir_pend_q || redirect_valid) ? S_DRAIN : S_R;
                end
            end
            S_R: begin
                if (redirect_valid) begin
                    halt_after_d = 1'b0;
                    if (req_done)  state_d = misalign ? S_HALT : S_IDLE;
                    else begin
                        halt_after_d = misalign;
                        state_d      = S_DRAIN;
                    end
                end else if (rvalid) begin
                    resv_d = resv_q - CW'(1);
                    // Beats ahead of a mid-block entry point are dropped.
                    keep   = beat_addr >= fetch_pc_q;
                    if (keep) begin
                        enq       = 1'b1;
                        enq_entry = '{pc: beat_addr,
                                      inst: (rresp != 2'b00) ? 32'h0 : rdata,
                                      fault: rresp != 2'b00};
                    end
                    if (keep && rresp != 2'b00) begin
                        resv_d = '0;
                        if (last_beat || !burst_q) state_d = S_HALT;
                        else begin
                            halt_after_d = 1'b1;
                            state_d      = S_DRAIN;
                        end
                    end else if (last_beat) begin
                        fetch_pc_d = base_q + 32'(BLOCK_SIZE);
                        state_d    = S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        if (!burst_q) begin
                            arvalid_d = 1'b1;
                            araddr_d  = beat_addr + 32'd4;
                            state_d   = S_AR;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) halt_after_d = misalign;
                if (req_done) begin
                    state_d      = (redirect_valid ? misalign : halt_after_q) ? S_HALT : S_IDLE;
                    halt_after_d = 1'b0;
                end
            end
            S_HALT: begin
                if (redirect_valid && !misalign) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Fetch queue. A redirect empties it; a misaligned target leaves a
        // single fault entry behind in slot 0.
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            resv_d  = '0;
            if (misalign) begin
                mem_d[0] = '{pc: redirect_pc, inst: 32'h0, fault: 1'b1};
                tail_d   = ptr_inc('0);
                count_d  = CW'(1);
            end
        end else begin
            if (enq) begin
                mem_d[tail_q] = enq_entry;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) head_d = ptr_inc(head_q);
            count_d = count_q + CW'(enq) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            base_q       <= '0;
            beat_q       <= '0;
            burst_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arburst_q    <= '0;
            redir_pend_q <= 1'b0;
            halt_after_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resv_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            burst_q      <= burst_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arburst_q    <= arburst_d;
            redir_pend_q <= redir_pend_d;
            halt_after_q <= halt_after_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resv_q       <= resv_d;
            mem_q        <= mem_d;
        end
    end

endmodule
